// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_port_arbiter_pkg
// Purpose : Shared types and constants for the register-file write-port
//           arbiter. The writeback request type is used as the payload of the
//           long-latency result FIFO.
// Contents: c_REG_ADDR_W, c_XLEN, wb_req_t, f_is_claim()
// Revision: 1.0 - initial release
// ============================================================================
package wb_port_arbiter_pkg;

  localparam int c_REG_ADDR_W = 5;
  localparam int c_XLEN       = 32;

  // One register-file write: destination and data.
  typedef struct packed {
    logic [c_REG_ADDR_W-1:0] rd;
    logic [c_XLEN-1:0]       data;
  } wb_req_t;

  // A write to x0 is architecturally a no-op and must never claim the port.
  function automatic logic f_is_claim(input logic we, input logic [c_REG_ADDR_W-1:0] rd);
    return we && (rd != '0);
  endfunction

endpackage : wb_port_arbiter_pkg
`default_nettype wire

// File: rtl/wb_port_arbiter_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Purpose : Generic single-clock FIFO. Push when full and pop when empty are
//           ignored. Simultaneous push and pop leave the count unchanged.
//           Pointers wrap naturally (DEPTH must be a power of 2, >= 2).
// Ports   : clk, rst_n (sync, active low)
//           i_push, i_data  - write side
//           i_pop, o_data   - read side (o_data shows the head, first-word
//                             fall-through)
//           o_full, o_empty, o_count - occupancy ($clog2(DEPTH)+1 bits)
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_count == c_FULL);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_port_arbiter
// Purpose : Shares the single register-file write port between the pipeline
//           writeback and a long-latency (mul/div) result stream. Pipeline
//           writes win; long-latency results queue in a FIFO and drain into
//           idle port cycles.
// Config  : define WBARB_STARVE_GUARD_EN to add a starvation guard that stalls
//           the pipeline for one cycle after STARVE_LIMIT blocked cycles of
//           the FIFO head. Undefined: wb_stall is tied low.
// Ports   : clk, rst_n (sync, active low)
//           RegWriteW/RdW/ResultW    - pipeline writeback request
//           ll_valid/ll_ready/ll_rd/ll_data - long-latency result handshake
//           rf_we/rf_rd/rf_wd        - register-file write port
//           ll_pending               - FIFO non-empty, to hazard unit
//           wb_stall                 - freeze MEM/WB and earlier (registered)
// Revision: 1.0 - initial release
// ============================================================================
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    RegWriteW,
  input  logic [c_REG_ADDR_W-1:0] RdW,
  input  logic [c_XLEN-1:0]       ResultW,
  input  logic                    ll_valid,
  output logic                    ll_ready,
  input  logic [c_REG_ADDR_W-1:0] ll_rd,
  input  logic [c_XLEN-1:0]       ll_data,
  output logic                    rf_we,
  output logic [c_REG_ADDR_W-1:0] rf_rd,
  output logic [c_XLEN-1:0]       rf_wd,
  output logic                    ll_pending,
  output logic                    wb_stall
);

  wb_req_t                 w_push_req;
  wb_req_t                 w_head;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic [$clog2(DEPTH):0]  w_count;
  logic                    w_pw;
  logic                    w_pipe_gnt;

  // ---------------------------------------------------------------------------
  // Long-latency result FIFO. rd=0 results complete the handshake but are
  // never stored, so they can never reach the port.
  // ---------------------------------------------------------------------------
  assign ll_ready   = !w_full;
  assign ll_pending = (w_count != '0);
  assign w_push     = ll_valid && ll_ready && (ll_rd != '0);
  assign w_push_req = '{rd: ll_rd, data: ll_data};

  sync_fifo #(
    .WIDTH ($bits(wb_req_t)),
    .DEPTH (DEPTH)
  ) u_ll_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_req),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // ---------------------------------------------------------------------------
  // Grant. During wb_stall the pipeline request is ignored (it is held
  // upstream and re-presented), so the head goes out unconditionally.
  // Both grants are suppressed in the reset cycle.
  // ---------------------------------------------------------------------------
  assign w_pw       = f_is_claim(RegWriteW, RdW);
  assign w_pipe_gnt = rst_n && !wb_stall && w_pw;
  assign w_pop      = rst_n && !w_empty && (wb_stall || !w_pw);

  always_comb begin
    rf_we = 1'b0;
    rf_rd = '0;
    rf_wd = '0;
    if (w_pipe_gnt) begin
      rf_we = 1'b1;
      rf_rd = RdW;
      rf_wd = ResultW;
    end else if (w_pop) begin
      rf_we = 1'b1;
      rf_rd = w_head.rd;
      rf_wd = w_head.data;
    end
  end

`ifdef WBARB_STARVE_GUARD_EN
  // ---------------------------------------------------------------------------
  // Starvation guard. The counter holds the number of consecutive cycles the
  // head has been blocked; reaching STARVE_LIMIT (assumed >= 2) schedules one
  // stall cycle in which the head is forced out.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLOCK = 2'd1,
    S_STALL = 2'd2
  } starve_state_e;

  localparam int                  c_SCNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_SCNT_W-1:0] c_LIMIT  = c_SCNT_W'(STARVE_LIMIT);

  starve_state_e         r_state;
  starve_state_e         w_state_nxt;
  logic [c_SCNT_W-1:0]   r_scnt;
  logic [c_SCNT_W-1:0]   w_scnt_nxt;
  logic [c_SCNT_W-1:0]   w_scnt_inc;
  logic                  w_head_blocked;

  assign w_head_blocked = !w_empty && !w_pop;
  assign w_scnt_inc     = r_scnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_scnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_scnt  <= w_scnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_scnt_nxt  = r_scnt;
    case (r_state)
      S_IDLE: begin
        if (w_head_blocked) begin
          w_state_nxt = S_BLOCK;
          w_scnt_nxt  = c_SCNT_W'(1);
        end else begin
          w_scnt_nxt  = '0;
        end
      end
      S_BLOCK: begin
        if (w_head_blocked) begin
          w_scnt_nxt = w_scnt_inc;
          if (w_scnt_inc == c_LIMIT) w_state_nxt = S_STALL;
        end else begin
          w_state_nxt = S_IDLE;
          w_scnt_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_scnt_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    wb_stall = 1'b0;
    if (r_state == S_STALL) wb_stall = 1'b1;
  end
`else
  assign wb_stall = 1'b0;
`endif

endmodule : wb_port_arbiter
`default_nettype wire
